// File: rtl/preadd_d_block_pipe_if.sv
// Pre-adder bus bundle: operands, control enables, config chain and results.
// ad_sat exists only when PREADD_SAT_EN is defined.
interface preadd_d_block_pipe_if #(
   parameter int DW = 27,
   parameter int BW = 18
);
   logic [DW-1:0] D;
   logic [DW-1:0] A2A1;
   logic [BW-1:0] B2B1;
   logic          in_valid;
   logic          CED;
   logic          CEAD;
   logic          RSTD;
   logic [4:0]    INMODE;
   logic          cfg_in;
   logic          cfg_en;
   logic          cfg_out;
   logic [DW-1:0] AD_DATA;
   logic          ad_valid;
   logic [DW-1:0] D_reg;
   logic          INMODEA;
   logic          INMODEB;
`ifdef PREADD_SAT_EN
   logic          ad_sat;

   modport master (
      output D, A2A1, B2B1, in_valid, CED, CEAD, RSTD, INMODE, cfg_in, cfg_en,
      input  cfg_out, AD_DATA, ad_valid, D_reg, INMODEA, INMODEB, ad_sat
   );
   modport slave (
      input  D, A2A1, B2B1, in_valid, CED, CEAD, RSTD, INMODE, cfg_in, cfg_en,
      output cfg_out, AD_DATA, ad_valid, D_reg, INMODEA, INMODEB, ad_sat
   );
`else
   modport master (
      output D, A2A1, B2B1, in_valid, CED, CEAD, RSTD, INMODE, cfg_in, cfg_en,
      input  cfg_out, AD_DATA, ad_valid, D_reg, INMODEA, INMODEB
   );
   modport slave (
      input  D, A2A1, B2B1, in_valid, CED, CEAD, RSTD, INMODE, cfg_in, cfg_en,
      output cfg_out, AD_DATA, ad_valid, D_reg, INMODEA, INMODEB
   );
`endif
endinterface

// File: rtl/preadd_d_block_pipe.sv
// DSP D/pre-adder front end with serial config, D register and 0..AD_STAGES AD pipe.
// Define PREADD_SAT_EN for signed saturating add with a pipelined ad_sat flag.

// One AD pipe stage: data (plus sat flag when enabled) and its valid tag.
module preadd_d_block_pipe_stage #(
   parameter int W = 27
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr_d_i,
   input  logic         clr_v_i,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   input  logic         v_i,
   output logic [W-1:0] q_o,
   output logic         v_o
);
   logic [W-1:0] data_q;
   logic         vld_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         if (clr_d_i)   data_q <= '0;
         else if (en_i) data_q <= d_i;
         if (clr_v_i)   vld_q  <= 1'b0;
         else if (en_i) vld_q  <= v_i;
      end
   end

   assign q_o = data_q;
   assign v_o = vld_q;
endmodule

module preadd_d_block_pipe #(
   parameter int DW            = 27,
   parameter int BW            = 18,
   parameter int AD_STAGES     = 3,
   parameter bit INPUT_FREEZED = 1'b0
) (
   input logic                 clk,
   input logic                 rstn,
   preadd_d_block_pipe_if.slave bus
);
`ifdef PREADD_SAT_EN
   localparam int W = DW + 1;
`else
   localparam int W = DW;
`endif

   // cfg_q = {PREADDINSEL, ADSEL[1], ADSEL[0], DREG, IS_RSTD_INVERTED}
   logic [4:0]    cfg_q, cfg_d;
   logic          preaddinsel, dreg, rstd_inv;
   logic [1:0]    adsel, lat;
   logic          rstd_x;
   logic [DW-1:0] d_reg_q, d_reg_d;
   logic [DW-1:0] d_sel, d_term, b_ext, pre_ab, ad_sum;
   logic [W-1:0]  s0;
   logic          v_in;
   logic          unused_inmode;

   assign cfg_d       = bus.cfg_en ? {bus.cfg_in, cfg_q[4:1]} : cfg_q;
   assign preaddinsel = cfg_q[4];
   assign adsel       = cfg_q[3:2];
   assign dreg        = cfg_q[1];
   assign rstd_inv    = cfg_q[0];
   assign lat         = (adsel > 2'(AD_STAGES)) ? 2'(AD_STAGES) : adsel;
   assign rstd_x      = bus.RSTD ^ rstd_inv;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cfg_q   <= '0;
         d_reg_q <= '0;
      end else begin
         cfg_q   <= cfg_d;
         d_reg_q <= d_reg_d;
      end
   end

   always_comb begin
      d_reg_d = d_reg_q;
      if (rstd_x)       d_reg_d = '0;
      else if (bus.CED) d_reg_d = bus.D;
   end

   assign d_sel  = (INPUT_FREEZED || dreg) ? d_reg_q : bus.D;
   assign d_term = (d_sel & {DW{bus.INMODE[2]}}) ^ {DW{bus.INMODE[3]}};
   assign b_ext  = DW'($signed(bus.B2B1));
   assign pre_ab = preaddinsel ? b_ext : bus.A2A1;

`ifdef PREADD_SAT_EN
   logic [DW:0] sum_x;
   logic        ovf;
   // Signed overflow shows up as disagreement between the two top bits.
   assign sum_x  = {d_term[DW-1], d_term} + {pre_ab[DW-1], pre_ab};
   assign ovf    = sum_x[DW] ^ sum_x[DW-1];
   assign ad_sum = !ovf     ? sum_x[DW-1:0] :
                   sum_x[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
   assign s0     = {ovf, ad_sum};
`else
   assign ad_sum = d_term + pre_ab;
   assign s0     = ad_sum;
`endif

   // Results shifted in while config is moving are never tagged valid.
   assign v_in = bus.in_valid & ~bus.cfg_en;

   logic [AD_STAGES-1:0][W-1:0] st_d, st_q;
   logic [AD_STAGES-1:0]        sv_d, sv_q;

   always_comb begin
      st_d    = '0;
      sv_d    = '0;
      st_d[0] = s0;
      sv_d[0] = v_in;
      for (int k = 1; k < AD_STAGES; k++) begin
         st_d[k] = st_q[k-1];
         sv_d[k] = sv_q[k-1];
      end
   end

   for (genvar g = 0; g < AD_STAGES; g++) begin : g_stg
      preadd_d_block_pipe_stage #(.W(W)) u_stg (
         .clk     (clk),
         .rstn    (rstn),
         .clr_d_i (rstd_x),
         .clr_v_i (rstd_x | bus.cfg_en),
         .en_i    (bus.CEAD),
         .d_i     (st_d[g]),
         .v_i     (sv_d[g]),
         .q_o     (st_q[g]),
         .v_o     (sv_q[g])
      );
   end

   logic [W-1:0] out_w;
   logic         out_v;

   always_comb begin
      out_w = s0;
      out_v = v_in;
      for (int k = 0; k < AD_STAGES; k++) begin
         if (lat == 2'(k + 1)) begin
            out_w = st_q[k];
            out_v = sv_q[k];
         end
      end
   end

   assign bus.AD_DATA  = out_w[DW-1:0];
   assign bus.ad_valid = out_v & ~bus.cfg_en;
`ifdef PREADD_SAT_EN
   assign bus.ad_sat   = out_w[DW];
`endif
   assign bus.D_reg    = d_reg_q;
   assign bus.cfg_out  = rstd_inv;
   assign bus.INMODEA  = preaddinsel ? 1'b1 : ~bus.INMODE[1];
   assign bus.INMODEB  = preaddinsel ? ~bus.INMODE[1] : 1'b1;
   assign unused_inmode = ^{bus.INMODE[4], bus.INMODE[0]};
endmodule
